// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: frames MSB-first bits into WIDTH-bit words,
// strobes each completed word and keeps a sticky framing-error flag.
module sipo_deser #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             bit_vld_i,
    input  logic             bit_i,
    input  logic             sof_i,
    output logic [WIDTH-1:0] q_o,
    output logic             q_vld_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_q_vld;
    logic             r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_sr    <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_q_vld <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_q_vld <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bit_vld_i) begin
                        if (sof_i) begin
                            r_sr    <= {r_sr[WIDTH-2:0], bit_i};
                            r_cnt   <= CW'(1);
                            r_state <= StShift;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                StShift: begin
                    if (bit_vld_i) begin
                        if (sof_i) begin
                            // Premature start: stale bits shift out before the next completion
                            r_err <= 1'b1;
                            r_sr  <= {r_sr[WIDTH-2:0], bit_i};
                            r_cnt <= CW'(1);
                        end else if (r_cnt == LAST_IDX) begin
                            r_q     <= {r_sr[WIDTH-2:0], bit_i};
                            r_q_vld <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= StIdle;
                        end else begin
                            r_sr  <= {r_sr[WIDTH-2:0], bit_i};
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign q_o     = r_q;
    assign q_vld_o = r_q_vld;
    assign busy_o  = (r_state == StShift);
    assign err_o   = r_err;

endmodule
